req_issue_queue: RTL and testbench
==================================

# req_issue_queue

Upstream request source for the fixed-latency req/ack responder. Accepts tagged jobs from a producer over a valid/ready port, buffers them in a small FIFO, and drives `req` into the responder. It holds `req` across back-to-back jobs so the responder chains transactions without returning to Idle. On each `ack` it retires the head job, reports its tag, and polices the handshake for timeouts and stray acks.

## Interface
- `DEPTH`, 4 — FIFO entries; power of two, ≥2.
- `TAG_W`, 8 — job tag width.
- `TIMEOUT`, 8 — max cycles from transaction start to `ack`; must exceed the nominal 5.
- `clk` in 1 — clock.
- `rst` in 1 — reset; synchronous, active-high.
- `in_valid` in 1 — producer has a job.
- `in_tag` in TAG_W — job tag.
- `in_ready` out 1 — FIFO can accept; `count < DEPTH`.
- `req` out 1 — request to responder.
- `req_tag` out TAG_W — tag of head entry; 0 when empty.
- `ack` in 1 — one-cycle acknowledge from responder (Moore output).
- `done_valid` out 1 — registered pulse, one cycle after an accepted `ack`.
- `done_tag` out TAG_W — tag retired by that `ack`.
- `err_timeout` out 1 — sticky; set on timeout; cleared only by `rst`.
- `err_stray` out 1 — sticky; set on `ack` with empty FIFO; cleared only by `rst`.
- `level` out clog2(DEPTH)+1 — current occupancy `count`.

## Operation
- FIFO: circular buffer with `wr_ptr`/`rd_ptr` (clog2(DEPTH) bits, natural wrap) and `count` (0..DEPTH).
- Push when `in_valid & in_ready`. Pop when `ack & count!=0`.
- Simultaneous push+pop: `count` is unchanged and both pointers advance.
- No pass-through when full: `in_ready=0` even if `ack` is high that cycle.
- `req` is combinational and depends only on `count` and `ack`: `req = (count>=2) | (count==1 & ~ack)`.
- Effect of `req`: during an ack cycle, `req` is high only if another job is already queued, so the responder re-enters s0 directly. A job pushed during the ack cycle is not visible until the next cycle.
- No combinational path from `in_valid` to `req`. There is no loop, because `ack` is a Moore output.
- FSM `st`, two states:
  - IDLE: `count==0`. Goes to BUSY when a push occurs.
  - BUSY: transaction outstanding. On `ack`, stays BUSY if `count>=2` or a push occurs that cycle; otherwise goes to IDLE.
- Timeout counter `tmo`:
  - Width clog2(TIMEOUT+1). Cleared in IDLE and on each `ack`; increments in BUSY otherwise; saturates at TIMEOUT.
  - `err_timeout` sets in the cycle after `tmo` reaches TIMEOUT.
  - The job is not dropped; `req` is held.
- `ack` with `count==0`: sets `err_stray`. No pop, no `done_valid`, pointers untouched.
- `done_tag` holds the popped head tag, registered. It retains its last value when `done_valid=0`.

## Timing
- Reset values: `in_ready=1`, `req=0`, `req_tag=0`, `done_valid=0`, `done_tag=0`, `err_timeout=0`, `err_stray=0`, `level=0`. Also `st=IDLE`, pointers=0, `tmo=0`.
- Reset mid-transaction discards all entries. A later `ack` from the responder then sets `err_stray`, which is the required behaviour.
- Push at cycle t: `count`/`level` update at t+1, and `req` is high at t+1.
- Responder behaviour: it samples `req` at t+1 (Idle) and acks at t+6. `done_valid` pulses at t+7.
- Back-to-back: with N jobs queued, acks arrive every 5 cycles. `req` stays high continuously through all but the last `ack` cycle, and drops low in the last `ack` cycle.
- Full FIFO with `ack`: the pop happens, and `in_ready` rises the following cycle.

## Test plan
- Reset, then idle 10 cycles → all outputs at reset values, `req=0`, no errors.
- Single push of tag 0x5A at t=2 → `req` high t=3..t=7 and low at t=8 (the `ack` cycle), giving `req=1` exactly 5 cycles. `done_valid=1` with `done_tag=0x5A` at t=9. `level` goes 1 then 0.
- Push 4 tags 0x01..0x04 in consecutive cycles (`DEPTH=4`):
  - `in_ready=0` once `level=4`.
  - Acks arrive every 5 cycles, `req` is high in every ack cycle except the 4th.
  - `done_tag` sequence is 01, 02, 03, 04.
- Fill to 4 and hold `in_valid=1` → push refused during the `ack` cycle. Push accepted the cycle after; final order preserved.
- Responder model withholds `ack` → `err_timeout` rises at cycle TIMEOUT+1 after transaction start and stays set. `req` stays high. A late `ack` still retires the job.
- Inject `ack` with empty FIFO → `err_stray=1`, `level` stays 0, no `done_valid`. Then `rst` clears `err_stray`.

Source files
------------

// File: rtl/req_issue_queue.sv
// Upstream job queue for the fixed-latency req/ack responder: buffers tagged jobs,
// holds req across queued jobs, retires the head on each ack and flags protocol errors.
module req_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 8,
  parameter int TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     in_ready,
  output logic                     req,
  output logic [TAG_W-1:0]         req_tag,
  input  logic                     ack,
  output logic                     done_valid,
  output logic [TAG_W-1:0]         done_tag,
  output logic                     err_timeout,
  output logic                     err_stray,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} st_t;

  st_t              st, st_nxt;
  logic [TAG_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic [TW-1:0]    tmo;
  logic             push, pop, empty, multi;

  assign empty    = (count == '0);
  assign multi    = (count >= (PW+1)'(2));
  assign in_ready = (count != (PW+1)'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = ack & ~empty;
  assign level    = count;

  // req looks only at occupancy and ack, so a push never reaches req in the same cycle
  assign req      = multi | (~empty & ~ack);
  assign req_tag  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (push) st_nxt = BUSY;
      BUSY:    if (ack && !multi && !push) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // Watchdog restarts on every ack so each chained transaction gets its own budget
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo <= '0;
    end else if (st == IDLE || ack) begin
      tmo <= '0;
    end else if (tmo != TW'(TIMEOUT)) begin
      tmo <= tmo + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_timeout <= 1'b0;
      err_stray   <= 1'b0;
      done_valid  <= 1'b0;
      done_tag    <= '0;
    end else begin
      err_timeout <= err_timeout | (tmo == TW'(TIMEOUT));
      err_stray   <= err_stray | (ack & empty);
      done_valid  <= pop;
      if (pop) done_tag <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_req_issue_queue.sv
// Directed bench for req_issue_queue: a 5-cycle responder model drives ack while
// per-cycle outputs are compared against hand-computed tables.
module tb_req_issue_queue;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 8;
  localparam int TIMEOUT = 8;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, req, ack;
  logic             done_valid, err_timeout, err_stray;
  logic [TAG_W-1:0] in_tag, req_tag, done_tag;
  logic [LW-1:0]    level;
  logic             resp_en = 1'b1;
  logic             stray_ack = 1'b0;
  int               resp_st = 0;
  int               vectors = 0;
  int               miscompares = 0;

  int lvl3 [25] = '{0,1,2,3,4,4,4,3,3,3,3,3,2,2,2,2,2,1,1,1,1,1,0,0,0};
  int lvl4 [30] = '{0,1,2,3,4,4,4,3,4,4,4,4,3,3,3,3,3,2,2,2,2,2,1,1,1,1,1,0,0,0};

  always #5 clk = ~clk;

  req_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_tag(in_tag), .in_ready(in_ready),
    .req(req), .req_tag(req_tag), .ack(ack), .done_valid(done_valid), .done_tag(done_tag),
    .err_timeout(err_timeout), .err_stray(err_stray), .level(level)
  );

  // Responder: samples req in Idle, acks five cycles later, chains if req is high in the ack cycle
  always @(posedge clk) begin
    if (rst) resp_st <= 0;
    else begin
      case (resp_st)
        0:       if (req) resp_st <= 1;
        5:       if (resp_en) resp_st <= req ? 1 : 0;
        default: resp_st <= resp_st + 1;
      endcase
    end
  end

  assign ack = (resp_st == 5 && resp_en) || stray_ack;

  task automatic checkOutput(input string tag, input int cyc, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s @c%0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [TAG_W-1:0] t, input logic sa);
    in_valid  = v;
    in_tag    = t;
    stray_ack = sa;
    #1;
  endtask

  task automatic doReset;
    rst = 1'b1;
    in_valid = 1'b0; in_tag = '0; stray_ack = 1'b0;
    nextCycle;
    nextCycle;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_tag = '0;
    nextCycle;

    // Reset, then 10 idle cycles
    doReset;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("idle_req", c, req, 0);
      nextCycle;
    end
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("rst_in_ready", 10, in_ready, 1);
    checkOutput("rst_req_tag", 10, req_tag, 0);
    checkOutput("rst_done_valid", 10, done_valid, 0);
    checkOutput("rst_done_tag", 10, done_tag, 0);
    checkOutput("rst_err_timeout", 10, err_timeout, 0);
    checkOutput("rst_err_stray", 10, err_stray, 0);
    checkOutput("rst_level", 10, level, 0);

    // Single job 0x5A: req for exactly 5 cycles, retired one cycle after ack
    doReset;
    for (int c = 0; c < 9; c++) begin
      applyStimulus(c == 0, 8'h5A, 1'b0);
      checkOutput("t1_req", c, req, (c >= 1 && c <= 5));
      checkOutput("t1_level", c, level, (c >= 1 && c <= 6));
      checkOutput("t1_done_valid", c, done_valid, (c == 7));
      if (c == 1) checkOutput("t1_req_tag", c, req_tag, 8'h5A);
      if (c == 7) begin
        checkOutput("t1_done_tag", c, done_tag, 8'h5A);
        checkOutput("t1_req_tag_empty", c, req_tag, 0);
      end
      nextCycle;
    end

    // Four back-to-back jobs fill the FIFO; req stays high until the last ack
    doReset;
    for (int c = 0; c < 25; c++) begin
      applyStimulus(c <= 3, 8'(c + 1), 1'b0);
      checkOutput("t2_req", c, req, (c >= 1 && c <= 20));
      checkOutput("t2_level", c, level, lvl3[c]);
      checkOutput("t2_in_ready", c, in_ready, (lvl3[c] != 4));
      checkOutput("t2_done_valid", c, done_valid, (c == 7 || c == 12 || c == 17 || c == 22));
      if (c == 7 || c == 12 || c == 17 || c == 22)
        checkOutput("t2_done_tag", c, done_tag, (c - 2) / 5);
      nextCycle;
    end

    // Full FIFO with a waiting producer: refused during the ack cycle, accepted after
    doReset;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(c <= 7, (c <= 3) ? 8'(8'h11 + c) : 8'h15, 1'b0);
      checkOutput("t3_req", c, req, (c >= 1 && c <= 25));
      checkOutput("t3_level", c, level, lvl4[c]);
      checkOutput("t3_in_ready", c, in_ready, (lvl4[c] != 4));
      checkOutput("t3_done_valid", c, done_valid,
                  (c == 7 || c == 12 || c == 17 || c == 22 || c == 27));
      if (c == 7 || c == 12 || c == 17 || c == 22 || c == 27)
        checkOutput("t3_done_tag", c, done_tag, 8'h11 + (c - 7) / 5);
      nextCycle;
    end

    // Withheld ack: timeout is flagged and sticky, req held, late ack still retires the job
    resp_en = 1'b0;
    doReset;
    for (int c = 0; c < 18; c++) begin
      resp_en = (c >= 15);
      applyStimulus(c == 0, 8'h77, 1'b0);
      checkOutput("t4_err_timeout", c, err_timeout, (c >= 10));
      checkOutput("t4_req", c, req, (c >= 1 && c <= 14));
      checkOutput("t4_level", c, level, (c >= 1 && c <= 15));
      checkOutput("t4_done_valid", c, done_valid, (c == 16));
      if (c == 16) checkOutput("t4_done_tag", c, done_tag, 8'h77);
      nextCycle;
    end
    resp_en = 1'b1;

    // Stray ack on an empty FIFO, then reset clears the flag
    doReset;
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t5_err_timeout_cleared", 0, err_timeout, 0);
    checkOutput("t5_req", 0, req, 0);
    nextCycle;
    for (int c = 1; c < 3; c++) begin
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("t5_err_stray", c, err_stray, 1);
      checkOutput("t5_level", c, level, 0);
      checkOutput("t5_done_valid", c, done_valid, 0);
      checkOutput("t5_in_ready", c, in_ready, 1);
      nextCycle;
    end
    doReset;
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("t5_err_stray_cleared", 0, err_stray, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
